scfifo_showahead: RTL and testbench
===================================

Name: scfifo_showahead

Overview:
Single-clock, parametrised successor to the team's dual-clock MLAB FIFO. Generalised depth and width, full 2**LOG_DEPTH capacity, always-on overflow/underflow protection and runtime-programmable almost thresholds. Adds a selectable show-ahead (first-word-fall-through) read mode and sticky error flags. Used for same-domain buffering between pipeline stages where no clock crossing exists.

Parameters:
LOG_DEPTH, 5, log2 of storage depth; legal range 2..10; DEPTH = 2**LOG_DEPTH words.
WIDTH, 20, data word width in bits; legal range 1..256.
SHOW_AHEAD, 0, 0 = normal mode (q updates after rdreq); 1 = show-ahead mode (q holds the head word whenever not empty).

Ports:
clk  input  1  clock; all logic on posedge.
aclr  input  1  reset; synchronous, active-high.
wrreq  input  1  write request.
data  input  WIDTH  write data.
rdreq  input  1  read request (SHOW_AHEAD=1: acknowledge/pop of the word on q).
q  output  WIDTH  read data.
full  output  1  no write accepted this cycle.
empty  output  1  no read accepted this cycle.
usedw  output  LOG_DEPTH+1  words held, 0..DEPTH.
almost_full_thr  input  LOG_DEPTH+1  almost_full threshold.
almost_empty_thr  input  LOG_DEPTH+1  almost_empty threshold.
almost_full  output  1  usedw >= almost_full_thr.
almost_empty  output  1  usedw <= almost_empty_thr.
overflow  output  1  sticky; a write was rejected.
underflow  output  1  sticky; a read was rejected.
clear_err  input  1  clears overflow and underflow.

Behaviour:
- Reset (aclr high at posedge): pointers=0, usedw=0, empty=1, full=0, almost_empty=1, almost_full=0, overflow=0, underflow=0, q=0. Memory contents are not cleared. Reset has priority over all requests in the same cycle.
- Accept rules are evaluated on the registered state at the start of the cycle:
  - wr_ok = wrreq & ~full.
  - rd_ok = rdreq & ~empty.
- Simultaneous requests:
  - Full with wrreq and rdreq: the read is accepted and the write is rejected.
  - Empty with wrreq and rdreq: the write is accepted and the read is rejected.
  - Otherwise, wr_ok and rd_ok together leave usedw unchanged.
- Counter: usedw_next = usedw + wr_ok - rd_ok, computed at width LOG_DEPTH+1 with no wrap. full = (usedw==DEPTH) and empty = (usedw==0), both registered.
- Pointers: LOG_DEPTH-bit wr/rd pointers increment on wr_ok/rd_ok and wrap modulo DEPTH naturally.
- Almost flags: derived from the registered usedw against the live threshold inputs. No combinational path from wrreq/rdreq to any flag. A threshold change takes effect on the following cycle.
- Normal mode (SHOW_AHEAD=0):
  - q is registered and loads mem[rd_ptr] on rd_ok, so data is valid one cycle after the accepted rdreq.
  - q holds its value otherwise.
  - After a write to an empty FIFO, empty deasserts 1 cycle later.
- Show-ahead mode (SHOW_AHEAD=1):
  - A one-word output register holds the head word. usedw counts it.
  - A write to an empty FIFO deasserts empty 2 cycles later: 1 cycle for storage, 1 cycle for prefetch. q is valid in the same cycle empty falls.
  - rd_ok pops the head. The next word appears on q the following cycle with no bubble while the storage RAM is not empty.
  - Empty is asserted only when the output register is invalid.
- Error flags:
  - overflow sets on wrreq & full; underflow sets on rdreq & empty.
  - clear_err clears both flags; a set event in the same cycle wins over clear_err.
  - Rejected requests change no other state.
- Mid-operation reset discards all words. The first post-reset write behaves as a write to an empty FIFO.

Optional Feature:
Macro SCFIFO_PARITY_EN.
- Defined: each word is stored with one even-parity bit (memory WIDTH+1 bits wide) and an extra output port parity_err (1 bit) is added.
  - parity_err is registered alongside q: high for the cycle q presents a word whose recomputed parity mismatches the stored bit.
  - parity_err is 0 at reset.
- Not defined: no parity bit, no parity_err port, memory WIDTH bits wide.

Decomposition:
- Package scfifo_pkg holds:
  - the function computing DEPTH from LOG_DEPTH;
  - the usedw width constant expression (LOG_DEPTH+1);
  - mode localparams MODE_NORMAL=0 and MODE_SHOW_AHEAD=1.
- One sub-module, scfifo_ram_1r1w: simple dual-port RAM, single clk, registered read, parameters WIDTH and ADDR_WIDTH, MLAB ramstyle.
- The top level contains pointers, counter, flags and the show-ahead prefetch logic.

Test Plan:
All scenarios use WIDTH=8, LOG_DEPTH=3 (DEPTH=8) unless stated.
1. Fill/drain, normal mode: write 0x01..0x08 on consecutive cycles -> full=1 and usedw=8 after the 8th write. Then 8 reads -> q=0x01..0x08, each 1 cycle after its rdreq; empty=1, usedw=0.
2. Overflow/underflow: 9th write while full -> overflow=1, usedw stays 8, data 0x09 is never read. Read while empty -> underflow=1. Pulse clear_err -> both flags 0.
3. Simultaneous requests at the boundaries:
   - full, wrreq+rdreq -> read accepted, usedw goes to 7, overflow=1;
   - empty, wrreq+rdreq -> usedw goes to 1, underflow=1;
   - usedw=4, wrreq+rdreq -> usedw stays 4.
4. Show-ahead latency (SHOW_AHEAD=1): single write of 0xA5 into an empty FIFO -> empty falls 2 cycles later with q=0xA5. Back-to-back writes of 0x10,0x11 then continuous rdreq -> q=0x10, then 0x11, on consecutive cycles.
5. Thresholds and wrap: almost_full_thr=6, almost_empty_thr=1 -> almost_full rises at usedw=6 and almost_empty falls at usedw=2. Run 20 write/read cycles with 3 words resident -> pointers wrap and data order is preserved.
6. Reset mid-operation: usedw=5, assert aclr together with wrreq -> next cycle usedw=0, empty=1, flags at reset values. With SCFIFO_PARITY_EN defined, flipping one stored bit via a bench force -> parity_err=1 for that word only.

Source files
------------

// File: rtl/scfifo_pkg.sv
// Shared constants and sizing helpers for the single-clock show-ahead FIFO.
package scfifo_pkg;

  localparam int MODE_NORMAL     = 0;
  localparam int MODE_SHOW_AHEAD = 1;

  // Storage depth in words for a given log2 depth.
  function automatic int depth_of(input int log_depth);
    return 1 << log_depth;
  endfunction

  // usedw must represent 0..DEPTH inclusive, hence one bit wider than a pointer.
  function automatic int usedw_width(input int log_depth);
    return log_depth + 1;
  endfunction

endpackage

// File: rtl/scfifo_ram_1r1w.sv
// Simple dual-port RAM, one clock, registered read port with synchronous clear
// of the read register only (array contents are never cleared).
module scfifo_ram_1r1w #(
  parameter int WIDTH      = 20,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [WIDTH-1:0]      wr_data,
  input  logic                  rd_en,
  input  logic                  rd_clr,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [WIDTH-1:0]      rd_data
);

  (* ramstyle = "MLAB" *) logic [WIDTH-1:0] mem [2**ADDR_WIDTH];

  // Write port.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Registered read; old data is returned on a same-address write.
  always_ff @(posedge clk) begin
    if (rd_clr)     rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/scfifo_showahead.sv
// Single-clock FIFO with optional show-ahead output, programmable almost
// thresholds and sticky overflow/underflow flags.
// Optional build macro SCFIFO_PARITY_EN: stores an even-parity bit per word
// and adds the parity_err output.
module scfifo_showahead
  import scfifo_pkg::*;
#(
  parameter int LOG_DEPTH  = 5,
  parameter int WIDTH      = 20,
  parameter int SHOW_AHEAD = MODE_NORMAL
) (
  input  logic                 clk,
  input  logic                 aclr,
  input  logic                 wrreq,
  input  logic [WIDTH-1:0]     data,
  input  logic                 rdreq,
  output logic [WIDTH-1:0]     q,
  output logic                 full,
  output logic                 empty,
  output logic [LOG_DEPTH:0]   usedw,
  input  logic [LOG_DEPTH:0]   almost_full_thr,
  input  logic [LOG_DEPTH:0]   almost_empty_thr,
  output logic                 almost_full,
  output logic                 almost_empty,
  output logic                 overflow,
  output logic                 underflow,
  input  logic                 clear_err
`ifdef SCFIFO_PARITY_EN
  ,
  output logic                 parity_err
`endif
);

  localparam int DEPTH = depth_of(LOG_DEPTH);
  localparam int UW    = usedw_width(LOG_DEPTH);
`ifdef SCFIFO_PARITY_EN
  localparam int MW    = WIDTH + 1;
`else
  localparam int MW    = WIDTH;
`endif
  localparam bit SA    = (SHOW_AHEAD == MODE_SHOW_AHEAD);

  localparam logic [UW-1:0]        CNT_ONE  = UW'(1);
  localparam logic [UW-1:0]        CNT_FULL = UW'(DEPTH);
  localparam logic [LOG_DEPTH-1:0] PTR_ONE  = LOG_DEPTH'(1);

  logic [LOG_DEPTH-1:0] wr_ptr, rd_ptr;
  logic [UW-1:0]        usedw_r, usedw_nxt;
  logic [UW-1:0]        ram_cnt, ram_cnt_nxt;   // words still in the array (excludes head register)
  logic                 head_vld, head_vld_nxt; // show-ahead: read register holds a live word
  logic                 full_r, empty_r, empty_nxt;
  logic                 af_r, ae_r, ovf_r, unf_r;
  logic                 wr_ok, rd_ok, fetch;
  logic [MW-1:0]        wr_word, rd_word;

  assign wr_ok = wrreq & ~full_r;
  assign rd_ok = rdreq & ~empty_r;

  // Array read scheduling, occupancy and next flag values.
  always_comb begin
    fetch = rd_ok;
    if (SA) fetch = (ram_cnt != '0) && (!head_vld || rd_ok);

    usedw_nxt = usedw_r;
    if (wr_ok && !rd_ok)      usedw_nxt = usedw_r + CNT_ONE;
    else if (rd_ok && !wr_ok) usedw_nxt = usedw_r - CNT_ONE;

    ram_cnt_nxt = ram_cnt;
    if (wr_ok && !fetch)      ram_cnt_nxt = ram_cnt + CNT_ONE;
    else if (fetch && !wr_ok) ram_cnt_nxt = ram_cnt - CNT_ONE;

    head_vld_nxt = head_vld;
    if (fetch)      head_vld_nxt = 1'b1;
    else if (rd_ok) head_vld_nxt = 1'b0;

    // In show-ahead mode a word is only readable once it sits in the read register.
    empty_nxt = SA ? !head_vld_nxt : (usedw_nxt == '0);
  end

  // Pointers, counters and registered status flags.
  always_ff @(posedge clk) begin
    if (aclr) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      usedw_r  <= '0;
      ram_cnt  <= '0;
      head_vld <= 1'b0;
      full_r   <= 1'b0;
      empty_r  <= 1'b1;
      af_r     <= 1'b0;
      ae_r     <= 1'b1;
      ovf_r    <= 1'b0;
      unf_r    <= 1'b0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + PTR_ONE;
      if (fetch) rd_ptr <= rd_ptr + PTR_ONE;
      usedw_r  <= usedw_nxt;
      ram_cnt  <= ram_cnt_nxt;
      head_vld <= head_vld_nxt;
      full_r   <= (usedw_nxt == CNT_FULL);
      empty_r  <= empty_nxt;
      af_r     <= (usedw_nxt >= almost_full_thr);
      ae_r     <= (usedw_nxt <= almost_empty_thr);
      ovf_r    <= (wrreq & full_r)  | (ovf_r & ~clear_err);
      unf_r    <= (rdreq & empty_r) | (unf_r & ~clear_err);
    end
  end

`ifdef SCFIFO_PARITY_EN
  assign wr_word    = {^data, data};
  assign q          = rd_word[WIDTH-1:0];
  assign parity_err = ^rd_word;
`else
  assign wr_word = data;
  assign q       = rd_word;
`endif

  scfifo_ram_1r1w #(
    .WIDTH      (MW),
    .ADDR_WIDTH (LOG_DEPTH)
  ) u_ram (
    .clk     (clk),
    .wr_en   (wr_ok & ~aclr),
    .wr_addr (wr_ptr),
    .wr_data (wr_word),
    .rd_en   (fetch & ~aclr),
    .rd_clr  (aclr),
    .rd_addr (rd_ptr),
    .rd_data (rd_word)
  );

  assign usedw        = usedw_r;
  assign full         = full_r;
  assign empty        = empty_r;
  assign almost_full  = af_r;
  assign almost_empty = ae_r;
  assign overflow     = ovf_r;
  assign underflow    = unf_r;

endmodule

// File: tb/tb_scfifo_showahead.sv
// Bench for scfifo_showahead: a normal-mode and a show-ahead instance share
// stimulus; each is compared every cycle against a queue-based model.
module tb_scfifo_showahead;

  localparam int LD    = 3;
  localparam int W     = 8;
  localparam int DEPTH = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         aclr, wrreq, rdreq, clear_err;
  logic [W-1:0] data;
  logic [LD:0]  af_thr, ae_thr;

  logic [W-1:0] q_n, q_s;
  logic [LD:0]  usedw_n, usedw_s;
  logic full_n, empty_n, af_n, ae_n, ovf_n, unf_n;
  logic full_s, empty_s, af_s, ae_s, ovf_s, unf_s;
`ifdef SCFIFO_PARITY_EN
  logic perr_n, perr_s;
`endif

  scfifo_showahead #(.LOG_DEPTH(LD), .WIDTH(W), .SHOW_AHEAD(0)) dut_n (
    .clk(clk), .aclr(aclr), .wrreq(wrreq), .data(data), .rdreq(rdreq), .q(q_n),
    .full(full_n), .empty(empty_n), .usedw(usedw_n),
    .almost_full_thr(af_thr), .almost_empty_thr(ae_thr),
    .almost_full(af_n), .almost_empty(ae_n), .overflow(ovf_n), .underflow(unf_n),
    .clear_err(clear_err)
`ifdef SCFIFO_PARITY_EN
    , .parity_err(perr_n)
`endif
  );

  scfifo_showahead #(.LOG_DEPTH(LD), .WIDTH(W), .SHOW_AHEAD(1)) dut_s (
    .clk(clk), .aclr(aclr), .wrreq(wrreq), .data(data), .rdreq(rdreq), .q(q_s),
    .full(full_s), .empty(empty_s), .usedw(usedw_s),
    .almost_full_thr(af_thr), .almost_empty_thr(ae_thr),
    .almost_full(af_s), .almost_empty(ae_s), .overflow(ovf_s), .underflow(unf_s),
    .clear_err(clear_err)
`ifdef SCFIFO_PARITY_EN
    , .parity_err(perr_s)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;
  int edge_idx = 0;

  // Normal-mode model: plain word queue, q loads on an accepted read.
  logic [W-1:0] nq[$];
  logic [W-1:0] n_qexp;
  bit n_ovf, n_unf, n_af, n_ae;

  // Show-ahead model: each word remembers the edge it was written on; the
  // head is shown once it has been stored for at least one edge.
  typedef struct {
    logic [W-1:0] d;
    int           e;
  } sa_ent_t;
  sa_ent_t sq[$];
  logic [W-1:0] s_qexp;
  bit s_vis, s_ovf, s_unf, s_af, s_ae;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s at edge %0d: got %0h expected %0h", tag, edge_idx, obs, exp);
    end
  endtask

  task automatic model_edge();
    bit full, emp, wok, rok;
    sa_ent_t ent;
    edge_idx++;
    if (aclr) begin
      nq.delete();
      sq.delete();
      n_qexp = '0; s_qexp = '0;
      n_ovf = 0; n_unf = 0; n_af = 0; n_ae = 1;
      s_ovf = 0; s_unf = 0; s_af = 0; s_ae = 1;
      s_vis = 0;
    end else begin
      full = (nq.size() == DEPTH);
      emp  = (nq.size() == 0);
      wok  = wrreq && !full;
      rok  = rdreq && !emp;
      n_ovf = (wrreq && full) || (n_ovf && !clear_err);
      n_unf = (rdreq && emp)  || (n_unf && !clear_err);
      if (rok) n_qexp = nq.pop_front();
      if (wok) nq.push_back(data);
      n_af = (nq.size() >= int'(af_thr));
      n_ae = (nq.size() <= int'(ae_thr));

      full = (sq.size() == DEPTH);
      emp  = !s_vis;
      wok  = wrreq && !full;
      rok  = rdreq && !emp;
      s_ovf = (wrreq && full) || (s_ovf && !clear_err);
      s_unf = (rdreq && emp)  || (s_unf && !clear_err);
      if (rok) void'(sq.pop_front());
      if (wok) begin
        ent.d = data;
        ent.e = edge_idx;
        sq.push_back(ent);
      end
      s_vis = (sq.size() > 0) && (sq[0].e < edge_idx);
      if (s_vis) s_qexp = sq[0].d;
      s_af = (sq.size() >= int'(af_thr));
      s_ae = (sq.size() <= int'(ae_thr));
    end
  endtask

  task automatic compare_all();
    chk("n_usedw", 32'(usedw_n), 32'(nq.size()));
    chk("n_full",  32'(full_n),  32'(nq.size() == DEPTH));
    chk("n_empty", 32'(empty_n), 32'(nq.size() == 0));
    chk("n_q",     32'(q_n),     32'(n_qexp));
    chk("n_afull", 32'(af_n),    32'(n_af));
    chk("n_aempty",32'(ae_n),    32'(n_ae));
    chk("n_ovf",   32'(ovf_n),   32'(n_ovf));
    chk("n_unf",   32'(unf_n),   32'(n_unf));
    chk("s_usedw", 32'(usedw_s), 32'(sq.size()));
    chk("s_full",  32'(full_s),  32'(sq.size() == DEPTH));
    chk("s_empty", 32'(empty_s), 32'(!s_vis));
    chk("s_q",     32'(q_s),     32'(s_qexp));
    chk("s_afull", 32'(af_s),    32'(s_af));
    chk("s_aempty",32'(ae_s),    32'(s_ae));
    chk("s_ovf",   32'(ovf_s),   32'(s_ovf));
    chk("s_unf",   32'(unf_s),   32'(s_unf));
`ifdef SCFIFO_PARITY_EN
    chk("n_perr",  32'(perr_n),  32'h0);
    chk("s_perr",  32'(perr_s),  32'h0);
`endif
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic cyc(input bit w, input bit r, input logic [W-1:0] d);
    wrreq = w;
    rdreq = r;
    data  = d;
    step();
  endtask

  task automatic do_reset();
    aclr = 1'b1;
    cyc(0, 0, '0);
    aclr = 1'b0;
  endtask

  initial begin
    int wr_pct, rd_pct;
    aclr = 1'b1; wrreq = 1'b0; rdreq = 1'b0; clear_err = 1'b0; data = '0;
    af_thr = 4'd6; ae_thr = 4'd1;
    step();
    step();
    aclr = 1'b0;

    // Fill then drain, checking data order and full/empty boundaries.
    for (int i = 1; i <= 8; i++) cyc(1, 0, W'(i));
    for (int i = 0; i < 8; i++)  cyc(0, 1, '0);
    cyc(0, 0, '0);

    // Overflow on a 9th write, underflow on an empty read, then clear.
    for (int i = 1; i <= 8; i++) cyc(1, 0, W'(8'h20 + i));
    cyc(1, 0, 8'h09);
    for (int i = 0; i < 8; i++) cyc(0, 1, '0);
    cyc(0, 1, '0);
    clear_err = 1'b1;
    cyc(0, 1, '0);
    cyc(0, 0, '0);
    clear_err = 1'b0;
    cyc(0, 0, '0);

    // Simultaneous requests at full, empty and mid-level.
    for (int i = 1; i <= 8; i++) cyc(1, 0, W'(8'h40 + i));
    cyc(1, 1, 8'h55);
    for (int i = 0; i < 8; i++) cyc(0, 1, '0);
    cyc(0, 0, '0);
    cyc(1, 1, 8'h66);
    for (int i = 0; i < 3; i++) cyc(1, 0, W'(8'h70 + i));
    cyc(0, 0, '0);
    for (int i = 0; i < 3; i++) cyc(1, 1, W'(8'h78 + i));
    clear_err = 1'b1;
    cyc(0, 0, '0);
    clear_err = 1'b0;

    // Show-ahead latency and back-to-back pops.
    do_reset();
    cyc(1, 0, 8'hA5);
    cyc(0, 0, '0);
    cyc(0, 0, '0);
    cyc(0, 1, '0);
    cyc(0, 0, '0);
    cyc(1, 0, 8'h10);
    cyc(1, 0, 8'h11);
    for (int i = 0; i < 3; i++) cyc(0, 1, '0);

    // Pointer wrap with three words resident.
    for (int i = 0; i < 3; i++) cyc(1, 0, W'(8'h90 + i));
    cyc(0, 0, '0);
    for (int i = 0; i < 20; i++) cyc(1, 1, W'($urandom));

    // Reset in the middle of traffic, together with a write.
    do_reset();
    for (int i = 0; i < 5; i++) cyc(1, 0, W'(8'hC0 + i));
    cyc(0, 0, '0);
    aclr = 1'b1;
    cyc(1, 0, 8'hEE);
    aclr = 1'b0;
    cyc(1, 0, 8'hD1);
    cyc(0, 0, '0);
    cyc(0, 0, '0);

    // Randomized traffic with fill-biased, drain-biased and balanced phases.
    for (int ph = 0; ph < 6; ph++) begin
      wr_pct = (ph % 3 == 0) ? 75 : (ph % 3 == 1) ? 25 : 50;
      rd_pct = 100 - wr_pct;
      for (int i = 0; i < 80; i++) begin
        clear_err = ($urandom_range(0, 15) == 0);
        aclr      = ($urandom_range(0, 99) == 0);
        if ($urandom_range(0, 31) == 0) af_thr = LD'(0) + 4'($urandom_range(0, 8));
        if ($urandom_range(0, 31) == 0) ae_thr = 4'($urandom_range(0, 8));
        cyc($urandom_range(0, 99) < wr_pct, $urandom_range(0, 99) < rd_pct, W'($urandom));
      end
    end
    clear_err = 1'b0;
    aclr      = 1'b0;
    cyc(0, 0, '0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
